flash_boot_loader: RTL and testbench
====================================

# flash_boot_loader

Boot front-end of `rv32i_soc`. After reset it streams a program image out of the external SPI flash and writes it word by word into instruction memory over a dedicated write port. It holds the core in reset until the image is loaded, then releases it. Simulation benches with preloaded memories skip the copy through the bypass input.

## Interface
Parameters:
- `IMEM_DEPTH`, 32*1024: imem size in 32-bit words.
- `BOOT_WORDS`, 1024: words copied. Legal range 1..IMEM_DEPTH; an elaboration-time assertion enforces it.
- `FLASH_BASE`, 24'h000000: flash byte address of the image.
- `CLK_DIV`, 2: sclk half-period in clk cycles. Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; one clock, synchronous, active-low.
- `i_boot_bypass`  in  1  skip the flash copy; sampled in the first cycle after reset release.
- `o_flash_sclk`  out  1  SPI clock, mode 0.
- `o_flash_cs_n`  out  1  flash chip select, active-low.
- `o_flash_mosi`  out  1  serial command/address out, MSB first.
- `i_flash_miso`  in  1  serial data in.
- `o_imem_we`  out  1  imem write strobe, one cycle per word.
- `o_imem_addr`  out  $clog2(IMEM_DEPTH)  imem word address.
- `o_imem_wdata`  out  32  imem write data.
- `o_core_reset_n`  out  1  reset to `rv32i_core`, active-low.
- `o_boot_done`  out  1  load complete; sticky until reset.

## Operation
- States:
  - IDLE: the single cycle after reset release. Go to DONE if `i_boot_bypass`=1, else to CMD.
  - CMD: shift 8 bits of 8'h03.
  - ADDR: shift the 24 bits of FLASH_BASE.
  - DATA: receive 32·BOOT_WORDS bits.
  - DONE: terminal state.
- CS and the SPI clock:
  - `o_flash_cs_n` stays low continuously from CMD entry until DONE (one continuous read). There is no per-word chip-select gap.
  - sclk idles low. A divider counter toggles sclk every CLK_DIV cycles.
- Bit timing:
  - mosi changes only while sclk is low. The first bit is driven in the same cycle cs_n falls; each next bit is driven on the falling-edge cycle.
  - miso is sampled on the rising-edge cycle. During DATA, mosi is held at 0.
- Word assembly: flash bytes arrive MSB-first within each byte. Word k = {b3,b2,b1,b0}, where b0 is the byte at FLASH_BASE+4k (little-endian).
- Write port:
  - `o_imem_we`=1 for exactly one cycle, the cycle after the rise that samples bit 31 of word k. That cycle carries addr=k and wdata=word k.
  - The write port never stalls, so sclk continues uninterrupted.
- Word address: counts 0..BOOT_WORDS-1 with no wrap. Between pulses `o_imem_addr` holds its last value; `o_imem_wdata` holds the last word.
- DONE: cs_n=1, sclk=0, mosi=0, we=0, `o_boot_done`=1, `o_core_reset_n`=1. All stay there until reset.
- Reset mid-operation (any state): the cycle after reset_n is sampled low, all outputs return to their reset values. cs_n rising aborts the flash read. After release, the load restarts from word 0.

## Timing
- Reset values: sclk 0, cs_n 1, mosi 0, imem_we 0, imem_addr 0, imem_wdata 0, core_reset_n 0, boot_done 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle numbering: T0 is the first cycle with reset_n=1 (IDLE). T1: cs_n=0, mosi=bit 7 of the command.
- Bit i (i from 0): rise at T1+(2i+1)·CLK_DIV, fall at T1+(2i+2)·CLK_DIV.
- N = 32+32·BOOT_WORDS bits. Final fall at T1+2·CLK_DIV·N. DONE outputs appear at T1+2·CLK_DIV·N+1, so cs_n is low for 2·CLK_DIV·N+1 cycles.
- Word k write pulse: at T1+(2·(32+32k+31)+1)·CLK_DIV+1.
- Bypass: DONE outputs at T1. cs_n is never asserted and no writes occur.

## Structure
- Package `flash_boot_pkg`: state enum `boot_state_e` (IDLE, CMD, ADDR, DATA, DONE), `FLASH_READ_CMD`=8'h03, `FLASH_ADDR_BITS`=24.
- Sub-module `flash_spi_shifter`: divider, sclk generation, 32-bit TX/RX shift registers, and rise/fall strobes.
- The top level holds the FSM, bit and word counters, the imem port, and the reset-release logic.

## Test plan
- BOOT_WORDS=4, CLK_DIV=1, flash bytes 00..0F → writes addr0=03020100, 1=07060504, 2=0B0A0908, 3=0F0E0D0C. DONE at T1+321.
- FLASH_BASE=24'h001000 → mosi bytes across rises 1–32 are 03,00,10,00 MSB-first. miso is ignored before rise 33.
- Flash word bytes A5,5A,FF,00 at base with CLK_DIV=3 → wdata=00FF5AA5. sclk period is 6 cycles; mosi and the miso model change only while sclk is low.
- i_boot_bypass=1 → cs_n never 0, imem_we never 1. boot_done and core_reset_n are 1 at T1.
- reset_n pulsed low for one cycle during DATA word 2 → the next cycle shows cs_n=1, we=0, core_reset_n=0. After release, writes restart at addr 0 with correct data.
- Continuous-read check: cs_n has no high glitch and sclk has no gap between words. There are exactly 4 we pulses, one cycle each.

Source files
------------

// File: rtl/flash_boot_pkg.sv
// Shared types and constants for the flash boot loader.
package flash_boot_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } boot_state_e;

    localparam logic [7:0]  FLASH_READ_CMD  = 8'h03;
    localparam int unsigned FLASH_ADDR_BITS = 24;

    // States in which the flash is selected and sclk runs.
    function automatic logic state_active(input boot_state_e s);
        return (s == CMD) || (s == ADDR) || (s == DATA);
    endfunction

    // Flash bytes arrive in address order; imem words are little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/flash_spi_shifter.sv
// SPI mode-0 bit engine: sclk divider, TX/RX shift registers and edge strobes.
module flash_spi_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        rise_o,
    output logic        fall_o,
    output logic [31:0] rx_word_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] div_q;
    logic            sclk_q;
    logic            rise_q;
    logic            fall_q;
    logic [31:0]     tx_q;
    logic [30:0]     rx_q;
    logic            tick;

    assign tick = (div_q == CntMax);

    // rise_q/fall_q mark the first cycle after sclk changes level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (!run_i) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            tx_q   <= load_i ? load_data_i : '0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (tick) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    fall_q <= 1'b1;
                    tx_q   <= {tx_q[30:0], 1'b0};
                end else begin
                    rise_q <= 1'b1;
                end
            end else begin
                div_q <= div_q + CntW'(1);
            end
            if (rise_q) begin
                rx_q <= {rx_q[29:0], miso_i};
            end
        end
    end

    assign sclk_o    = sclk_q;
    assign mosi_o    = tx_q[31];
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign rx_word_o = {rx_q, miso_i};

endmodule

// File: rtl/flash_boot_loader.sv
// Boot front-end: streams the boot image from SPI flash into imem, then releases the core.
module flash_boot_loader
    import flash_boot_pkg::*;
#(
    parameter int unsigned                    IMEM_DEPTH = 32 * 1024,
    parameter int unsigned                    BOOT_WORDS = 1024,
    parameter logic [FLASH_ADDR_BITS-1:0]     FLASH_BASE = 24'h000000,
    parameter int unsigned                    CLK_DIV    = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_boot_bypass,
    output logic                          o_flash_sclk,
    output logic                          o_flash_cs_n,
    output logic                          o_flash_mosi,
    input  logic                          i_flash_miso,
    output logic                          o_imem_we,
    output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
    output logic [31:0]                   o_imem_wdata,
    output logic                          o_core_reset_n,
    output logic                          o_boot_done
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);
    localparam logic [AW-1:0] LastWord = AW'(BOOT_WORDS - 1);

    if (IMEM_DEPTH < 2 || BOOT_WORDS == 0 || BOOT_WORDS > IMEM_DEPTH) begin : g_bad_boot_words
        $error("flash_boot_loader: BOOT_WORDS must be in 1..IMEM_DEPTH");
    end
    if (CLK_DIV == 0) begin : g_bad_clk_div
        $error("flash_boot_loader: CLK_DIV must be at least 1");
    end

    boot_state_e   state_q;
    boot_state_e   state_d;
    logic [4:0]    bit_cnt_q;
    logic [AW-1:0] word_cnt_q;
    logic          last_q;
    logic          cs_n_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          core_reset_n_q;
    logic          boot_done_q;

    logic          spi_run;
    logic          spi_load;
    logic          spi_rise;
    logic          spi_fall;
    logic          spi_sclk;
    logic          spi_mosi;
    logic [31:0]   spi_rx_word;
    logic          word_end;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_boot_bypass ? DONE : CMD;
            CMD:     if (spi_rise && bit_cnt_q == 5'd7) state_d = ADDR;
            ADDR:    if (spi_rise && bit_cnt_q == 5'd31) state_d = DATA;
            DATA:    if (spi_fall && last_q) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Gating on both states keeps the divider at zero in the first CMD cycle
    // and parks sclk low in the same edge that enters DONE.
    assign spi_run  = state_active(state_q) && state_active(state_d);
    assign spi_load = (state_q == IDLE) && (state_d == CMD);
    assign word_end = (state_q == DATA) && spi_rise && (bit_cnt_q == 5'd31);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            word_cnt_q     <= '0;
            last_q         <= 1'b0;
            cs_n_q         <= 1'b1;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            core_reset_n_q <= 1'b0;
            boot_done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cs_n_q  <= !state_active(state_d);
            we_q    <= word_end;
            if (spi_rise) begin
                bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (word_end) begin
                addr_q  <= word_cnt_q;
                wdata_q <= bswap32(spi_rx_word);
                if (word_cnt_q == LastWord) begin
                    last_q <= 1'b1;
                end else begin
                    word_cnt_q <= word_cnt_q + AW'(1);
                end
            end
            if (state_d == DONE) begin
                core_reset_n_q <= 1'b1;
                boot_done_q    <= 1'b1;
            end
        end
    end

    flash_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .reset_n    (reset_n),
        .run_i      (spi_run),
        .load_i     (spi_load),
        .load_data_i({FLASH_READ_CMD, FLASH_BASE}),
        .miso_i     (i_flash_miso),
        .sclk_o     (spi_sclk),
        .mosi_o     (spi_mosi),
        .rise_o     (spi_rise),
        .fall_o     (spi_fall),
        .rx_word_o  (spi_rx_word)
    );

    assign o_flash_sclk   = spi_sclk;
    assign o_flash_mosi   = spi_mosi;
    assign o_flash_cs_n   = cs_n_q;
    assign o_imem_we      = we_q;
    assign o_imem_addr    = addr_q;
    assign o_imem_wdata   = wdata_q;
    assign o_core_reset_n = core_reset_n_q;
    assign o_boot_done    = boot_done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: two instances (CLK_DIV 1 and 3) against a behavioural SPI flash.
module tb_flash_boot_loader;

    localparam int unsigned DEPTH = 16;
    localparam logic [23:0] BASE  = 24'h001000;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n [2];
    logic        bypass  [2];
    logic        sclk    [2];
    logic        cs_n    [2];
    logic        mosi    [2];
    logic        miso    [2];
    logic        we      [2];
    logic [3:0]  addr    [2];
    logic [31:0] wdata   [2];
    logic        core_rn [2];
    logic        done    [2];

    logic [7:0]  img [2][16];
    exp_t        sb [$];
    int          total;
    int          bad;

    flash_boot_loader #(
        .IMEM_DEPTH(DEPTH), .BOOT_WORDS(4), .FLASH_BASE(BASE), .CLK_DIV(1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n[0]), .i_boot_bypass(bypass[0]),
        .o_flash_sclk(sclk[0]), .o_flash_cs_n(cs_n[0]), .o_flash_mosi(mosi[0]),
        .i_flash_miso(miso[0]), .o_imem_we(we[0]), .o_imem_addr(addr[0]),
        .o_imem_wdata(wdata[0]), .o_core_reset_n(core_rn[0]), .o_boot_done(done[0])
    );

    flash_boot_loader #(
        .IMEM_DEPTH(DEPTH), .BOOT_WORDS(1), .FLASH_BASE(BASE), .CLK_DIV(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n[1]), .i_boot_bypass(bypass[1]),
        .o_flash_sclk(sclk[1]), .o_flash_cs_n(cs_n[1]), .o_flash_mosi(mosi[1]),
        .i_flash_miso(miso[1]), .o_imem_we(we[1]), .o_imem_addr(addr[1]),
        .o_imem_wdata(wdata[1]), .o_core_reset_n(core_rn[1]), .o_boot_done(done[1])
    );

    // Flash model: decodes command/address from the first 32 rises, then returns
    // image bytes MSB-first, changing miso only while sclk is low.
    int          fbit  [2];
    logic [31:0] fca   [2];
    logic        fprev [2];
    int          off;
    int          bi;
    logic [7:0]  byt;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs_n[d] !== 1'b0) begin
                fbit[d] = 0;
                fca[d]  = '0;
                miso[d] = 1'b0;
            end else begin
                if (sclk[d] === 1'b1 && fprev[d] !== 1'b1) begin
                    if (fbit[d] < 32) fca[d] = {fca[d][30:0], mosi[d]};
                    fbit[d] = fbit[d] + 1;
                end
                if (sclk[d] === 1'b0) begin
                    if (fbit[d] < 32) begin
                        miso[d] = 1'($urandom);
                    end else begin
                        off = int'(fca[d][23:0] - BASE) + (fbit[d] - 32) / 8;
                        bi  = 7 - (fbit[d] - 32) % 8;
                        byt = (fca[d][31:24] == 8'h03 && off >= 0 && off < 16) ? img[d][off] : 8'h00;
                        miso[d] = byt[bi];
                    end
                end
            end
            fprev[d] = sclk[d];
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++;
            if ({sclk[d], cs_n[d], mosi[d], we[d], core_rn[d], done[d]} !== 6'b010000) begin
                bad++;
                $display("FAIL reset_ctl dut%0d: got sclk,cs_n,mosi,we,core_rn,done=%b want 010000",
                         d, {sclk[d], cs_n[d], mosi[d], we[d], core_rn[d], done[d]});
            end
            total++;
            if (addr[d] !== 4'd0 || wdata[d] !== 32'd0) begin
                bad++;
                $display("FAIL reset_data dut%0d: got addr=%h wdata=%h want 0/0", d, addr[d], wdata[d]);
            end
        end
    endtask

    task automatic test_load();
        exp_t        e;
        int          done_c = -1;
        int          sclk_bad = 0;
        int          cs_bad = 0;
        int          mosi_bad = 0;
        int          wes = 0;
        int          rises = 0;
        logic [31:0] frame = '0;
        logic        prev_s = 1'b0;
        for (int i = 0; i < 16; i++) img[0][i] = 8'(i);
        for (int k = 0; k < 4; k++)
            sb.push_back('{128 + 64 * k, 4'(k),
                           {img[0][4*k+3], img[0][4*k+2], img[0][4*k+1], img[0][4*k]}});
        bypass[0]  = 1'b0;
        reset_n[0] = 1'b1;
        for (int c = 0; c <= 330; c++) begin
            @(negedge clk);
            if (c == 0) begin
                total++;
                if (cs_n[0] !== 1'b0 || mosi[0] !== 1'b0 || sclk[0] !== 1'b0 || core_rn[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL load_t1: got cs_n=%b mosi=%b sclk=%b core_rn=%b want 0 0 0 0",
                             cs_n[0], mosi[0], sclk[0], core_rn[0]);
                end
            end
            if (cs_n[0] !== ((c <= 320) ? 1'b0 : 1'b1)) cs_bad++;
            if (sclk[0] !== ((c <= 320) ? 1'(c % 2) : 1'b0)) sclk_bad++;
            if (sclk[0] === 1'b1 && prev_s === 1'b0) begin
                rises++;
                if (rises <= 32) frame = {frame[30:0], mosi[0]};
                else if (mosi[0] !== 1'b0) mosi_bad++;
            end
            prev_s = sclk[0];
            if (we[0] === 1'b1) begin
                wes++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL load_we_unexpected: got write at cycle %0d addr=%h want none", c, addr[0]);
                end else begin
                    e = sb.pop_front();
                    if (c != e.cyc || addr[0] !== e.addr || wdata[0] !== e.data) begin
                        bad++;
                        $display("FAIL load_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                 c, addr[0], wdata[0], e.cyc, e.addr, e.data);
                    end
                end
            end
            if (done[0] === 1'b1 && done_c < 0) done_c = c;
        end
        total++;
        if (frame !== {8'h03, BASE}) begin
            bad++;
            $display("FAIL load_cmd_addr: got %h want %h", frame, {8'h03, BASE});
        end
        total++;
        if (mosi_bad != 0) begin bad++; $display("FAIL load_mosi_data: got %0d nonzero bits want 0", mosi_bad); end
        total++;
        if (cs_bad != 0) begin bad++; $display("FAIL load_cs_cont: got %0d bad cycles want 0", cs_bad); end
        total++;
        if (sclk_bad != 0) begin bad++; $display("FAIL load_sclk: got %0d bad cycles want 0", sclk_bad); end
        total++;
        if (wes != 4) begin bad++; $display("FAIL load_we_count: got %0d want 4", wes); end
        total++;
        if (done_c != 321) begin bad++; $display("FAIL load_done_cycle: got %0d want 321", done_c); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL load_sb_left: got %0d want 0", sb.size()); end
        total++;
        if ({cs_n[0], sclk[0], mosi[0], we[0], core_rn[0], done[0]} !== 6'b100011) begin
            bad++;
            $display("FAIL load_done_state: got %b want 100011",
                     {cs_n[0], sclk[0], mosi[0], we[0], core_rn[0], done[0]});
        end
    endtask

    task automatic test_clkdiv3();
        exp_t e;
        int   done_c = -1;
        int   sclk_bad = 0;
        int   cs_bad = 0;
        int   mosi_bad = 0;
        int   wes = 0;
        logic prev_m = 1'b0;
        for (int i = 0; i < 16; i++) img[1][i] = 8'h00;
        img[1][0] = 8'hA5;
        img[1][1] = 8'h5A;
        img[1][2] = 8'hFF;
        img[1][3] = 8'h00;
        sb.push_back('{382, 4'd0, 32'h00FF5AA5});
        bypass[1]  = 1'b0;
        reset_n[1] = 1'b1;
        for (int c = 0; c <= 395; c++) begin
            @(negedge clk);
            if (cs_n[1] !== ((c <= 384) ? 1'b0 : 1'b1)) cs_bad++;
            if (sclk[1] !== ((c <= 384) ? 1'((c / 3) % 2) : 1'b0)) sclk_bad++;
            if (sclk[1] === 1'b1 && mosi[1] !== prev_m) mosi_bad++;
            prev_m = mosi[1];
            if (we[1] === 1'b1) begin
                wes++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL div3_we_unexpected: got write at cycle %0d want none", c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.cyc || addr[1] !== e.addr || wdata[1] !== e.data) begin
                        bad++;
                        $display("FAIL div3_write: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                 c, addr[1], wdata[1], e.cyc, e.addr, e.data);
                    end
                end
            end
            if (done[1] === 1'b1 && done_c < 0) done_c = c;
        end
        total++;
        if (sclk_bad != 0) begin bad++; $display("FAIL div3_sclk: got %0d bad cycles want 0", sclk_bad); end
        total++;
        if (cs_bad != 0) begin bad++; $display("FAIL div3_cs: got %0d bad cycles want 0", cs_bad); end
        total++;
        if (mosi_bad != 0) begin bad++; $display("FAIL div3_mosi_high: got %0d changes want 0", mosi_bad); end
        total++;
        if (wes != 1) begin bad++; $display("FAIL div3_we_count: got %0d want 1", wes); end
        total++;
        if (done_c != 385) begin bad++; $display("FAIL div3_done_cycle: got %0d want 385", done_c); end
    endtask

    task automatic test_bypass();
        int cs_low = 0;
        int we_hi = 0;
        reset_n[0] = 1'b0;
        bypass[0]  = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (done[0] !== 1'b0 || core_rn[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_prereset: got done=%b core_rn=%b want 0 0", done[0], core_rn[0]);
        end
        reset_n[0] = 1'b1;
        @(negedge clk);
        total++;
        if (done[0] !== 1'b1 || core_rn[0] !== 1'b1 || cs_n[0] !== 1'b1) begin
            bad++;
            $display("FAIL bypass_t1: got done=%b core_rn=%b cs_n=%b want 1 1 1", done[0], core_rn[0], cs_n[0]);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cs_n[0] !== 1'b1) cs_low++;
            if (we[0] !== 1'b0) we_hi++;
        end
        total++;
        if (cs_low != 0 || we_hi != 0) begin
            bad++;
            $display("FAIL bypass_quiet: got cs_low=%0d we_hi=%0d want 0 0", cs_low, we_hi);
        end
        bypass[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   done_c = -1;
        reset_n[0] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++)
            sb.push_back('{128 + 64 * k, 4'(k),
                           {img[0][4*k+3], img[0][4*k+2], img[0][4*k+1], img[0][4*k]}});
        reset_n[0] = 1'b1;
        for (int c = 0; c <= 220; c++) begin
            @(negedge clk);
            if (we[0] === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL mid_we_unexpected: got write at cycle %0d want none", c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.cyc || addr[0] !== e.addr || wdata[0] !== e.data) begin
                        bad++;
                        $display("FAIL mid_write1: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                 c, addr[0], wdata[0], e.cyc, e.addr, e.data);
                    end
                end
            end
        end
        reset_n[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({cs_n[0], we[0], core_rn[0], sclk[0], done[0]} !== 5'b10000) begin
            bad++;
            $display("FAIL mid_reset_state: got cs_n,we,core_rn,sclk,done=%b want 10000",
                     {cs_n[0], we[0], core_rn[0], sclk[0], done[0]});
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL mid_first_words: got %0d left want 0", sb.size()); end
        reset_n[0] = 1'b1;
        for (int k = 0; k < 4; k++)
            sb.push_back('{128 + 64 * k, 4'(k),
                           {img[0][4*k+3], img[0][4*k+2], img[0][4*k+1], img[0][4*k]}});
        for (int c = 0; c <= 330; c++) begin
            @(negedge clk);
            if (we[0] === 1'b1) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL mid_we_unexpected2: got write at cycle %0d want none", c);
                end else begin
                    e = sb.pop_front();
                    if (c != e.cyc || addr[0] !== e.addr || wdata[0] !== e.data) begin
                        bad++;
                        $display("FAIL mid_write2: got cyc=%0d addr=%h data=%h want cyc=%0d addr=%h data=%h",
                                 c, addr[0], wdata[0], e.cyc, e.addr, e.data);
                    end
                end
            end
            if (done[0] === 1'b1 && done_c < 0) done_c = c;
        end
        total++;
        if (done_c != 321) begin bad++; $display("FAIL mid_done_cycle: got %0d want 321", done_c); end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL mid_sb_left: got %0d want 0", sb.size()); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int d = 0; d < 2; d++) begin
            reset_n[d] = 1'b0;
            bypass[d]  = 1'b0;
        end
        test_reset();
        test_load();
        test_clkdiv3();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
